// File: rtl/alu_core.sv
// Multi-cycle 8-bit ALU with a start/done handshake.
// add/and/xor/illegal complete one edge after capture; mul completes MUL_LAT edges after capture.
module alu_core #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, WAIT_LOW} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic        err_q, err_d;
  logic [15:0] calc;
  logic        illegal;

  always_comb begin
    calc    = 16'h0000;
    illegal = 1'b0;
    case (op_q)
      OP_ADD:  calc = 16'(a_q) + 16'(b_q);
      OP_AND:  calc = {8'h00, a_q & b_q};
      OP_XOR:  calc = {8'h00, a_q ^ b_q};
      OP_MUL:  calc = 16'(a_q) * 16'(b_q);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d  = A;
          b_d  = B;
          op_d = op;
          // Only mul needs extra edges; everything else finishes on the next edge.
          cnt_d   = (op == OP_MUL) ? MUL_CNT : 4'd0;
          state_d = (op == OP_NOP) ? IDLE : EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = calc;
          err_d   = illegal;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:     state_d = start ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
      cnt_q   <= 4'd0;
      res_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign done   = (state_q == DONE);
  assign busy   = (state_q == EXEC) || (state_q == DONE);
  assign err    = err_q;
  assign result = res_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: driver pushes expected completions, a negedge monitor checks them.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  A = 8'h00, B = 8'h00;
  logic [2:0]  op = 3'b000;
  logic        start = 1'b0;
  logic        done, busy, err;
  logic [15:0] result;

  alu_core #(.MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .done(done), .result(result), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("err", {15'b0, err}, {15'b0, e.err});
        chk("done_cycle", 16'(cyc), 16'(e.due));
      end
    end
  end

  // Issue a command, hold start until done, then optionally keep start high extra cycles.
  task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] res, input logic e, input int lat,
                         input int hold_extra, input bit drop_early);
    exp_t x;
    bit got;
    @(negedge clk);
    A = a; B = b; op = o; start = 1'b1;
    x.res = res; x.err = e; x.due = cyc + 1 + lat;
    sb.push_back(x);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      // Scramble inputs after capture; only the captured values may be used.
      A = ~a; B = ~b; op = 3'b001;
      if (drop_early) start = 1'b0;
      chk("busy_active", {15'b0, busy}, 16'h0001);
      if (done) begin got = 1; break; end
    end
    if (!got) begin
      total++;
      $display("FAIL done_timeout: got no done want done within 20 cycles");
    end
    for (int i = 0; i < hold_extra; i++) begin
      @(negedge clk);
      chk("wait_low_busy", {15'b0, busy}, 16'h0000);
    end
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_done", {15'b0, done}, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_err", {15'b0, err}, 16'h0000);
    chk("rst_result", result, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_cmd(3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0, 1, 0, 0);
    run_cmd(3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 3, 0, 0);
    run_cmd(3'b011, 8'hA5, 8'h0F, 16'h00AA, 1'b0, 1, 0, 0);

    // no_op: one edge of start, no done, busy stays low, result kept.
    @(negedge clk);
    op = 3'b000; A = 8'h12; B = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nop_busy", {15'b0, busy}, 16'h0000);
    repeat (3) @(negedge clk);
    chk("nop_result_kept", result, 16'h00AA);

    run_cmd(3'b111, 8'h55, 8'h66, 16'h0000, 1'b1, 1, 0, 0);
    run_cmd(3'b001, 8'h01, 8'h02, 16'h0003, 1'b0, 1, 4, 0);
    run_cmd(3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1, 0, 0);
    // Abandoned request still completes.
    run_cmd(3'b100, 8'h12, 8'h34, 16'h03A8, 1'b0, 3, 0, 1);
    repeat (2) @(negedge clk);
    chk("hold_result", result, 16'h03A8);

    // Reset mid-mul, between E0+1 and E0+2: no done may follow.
    @(negedge clk);
    op = 3'b100; A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(posedge clk);   // E0
    @(posedge clk);   // E0+1
    #2 reset = 1'b1;
    #1;
    chk("midrst_done", {15'b0, done}, 16'h0000);
    chk("midrst_busy", {15'b0, busy}, 16'h0000);
    chk("midrst_result", result, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", {15'b0, busy}, 16'h0000);

    run_cmd(3'b001, 8'h7F, 8'h01, 16'h0080, 1'b0, 1, 0, 0);
    repeat (3) @(negedge clk);

    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk.
REQ-003 SHALL have port: A  input  8  operand A, unsigned bit pattern.
REQ-004 SHALL have port: B  input  8  operand B, unsigned bit pattern.
REQ-005 SHALL have port: op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101-111 illegal.
REQ-006 SHALL have port: start  input  1  command request; held high by requester until done is observed.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: result  output  16  operation result; valid while done=1, held until the next done.
REQ-009 SHALL have port: busy  output  1  high from capture until the cycle in which done is high, inclusive.
REQ-010 SHALL have port: err  output  1  high together with done when the completed opcode was illegal.
REQ-011 SHALL have parameter MUL_LAT, default 3, meaning: edges from capture to done for mul, legal range 2..8.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE, WAIT_LOW; reset state is IDLE.
REQ-013 SHALL, in IDLE, capture A, B, op into internal registers at the first rising edge where start=1; this edge is E0.
REQ-014 SHALL, for captured op=no_op, return to IDLE at E0 with no done pulse and busy remaining 0.
REQ-015 SHALL, for add/and/xor, assert done and drive result at edge E0+1 (state DONE).
REQ-016 SHALL, for mul, stay in EXEC with a down-counter and assert done and result at edge E0+MUL_LAT.
REQ-017 SHALL, for illegal op, assert done with err=1 and result=16'h0000 at edge E0+1.
REQ-018 SHALL compute add as zero-extended 9-bit sum A+B; and and xor zero-extended to 16 bits; mul as full 16-bit unsigned A*B; no overflow is possible.
REQ-019 SHALL hold done (and err) high for exactly one cycle, cleared at the following edge.
REQ-020 SHALL, leaving DONE, enter IDLE if start=0 at that edge, otherwise WAIT_LOW.
REQ-021 SHALL remain in WAIT_LOW until start is sampled 0, then enter IDLE; a new command needs start sampled 0 for at least one edge after done.
REQ-022 SHALL ignore changes on A, B, op and start while in EXEC or DONE; only captured values are used.
REQ-023 SHALL keep result unchanged outside done cycles, including across no_op commands.
REQ-024 SHALL treat start low again before done (request abandoned) as don't-care: the operation completes and pulses done normally.

Reset
REQ-025 SHALL, on reset assertion, set done=0, err=0, busy=0, result=16'h0000, state=IDLE, and clear captured operands and counter asynchronously.
REQ-026 SHALL, on reset asserted mid-operation, abort that operation with no done pulse, at any time including the done cycle.
REQ-027 SHALL accept a new command at the first rising edge after reset deassertion where start=1.

Verification
REQ-028 SHALL verify: add A=8'hFF, B=8'h01, start held -> done one cycle at E0+1, result=16'h0100, err=0.
REQ-029 SHALL verify: mul A=8'hFF, B=8'hFF, MUL_LAT=3 -> done at E0+3 only, result=16'hFE01, busy high from E0 through done.
REQ-030 SHALL verify: xor A=8'hA5, B=8'h0F, then no_op with start for one edge -> done once, result=16'h00AA retained; no done for no_op.
REQ-031 SHALL verify: op=3'b111 -> done and err at E0+1, result=16'h0000.
REQ-032 SHALL verify: start kept high 4 cycles after done -> no second done, state WAIT_LOW until start low; next and A=8'hF0, B=8'h3C -> result=16'h0030.
REQ-033 SHALL verify: reset asserted at E0+1 of mul, between clock edges -> done, busy, result go 0 immediately; no done later.
